// File: rtl/q_ringdown_meter_pkg.sv
// q_meter_pkg: shared FSM encoding and constants for the Q ring-down meter.
package q_meter_pkg;
    typedef enum logic [2:0] {IDLE, EXCITE, WAIT_HI, COUNT, DONE, SETTLE} state_t;
    localparam int Q_SAT     = 1023;
    localparam int AVG_DEPTH = 4;
    localparam int AVG_SHIFT = 2;
endpackage

// File: rtl/q_ringdown_meter_if.sv
// q_ringdown_meter_if: resonator-side and result-side signals of the Q meter.
interface q_ringdown_meter_if #(parameter int BUS_WIDTH = 10);
    logic                 enable;
    logic                 osc_in;
    logic                 env_hi;
    logic                 env_lo;
    logic                 excite;
    logic [BUS_WIDTH-1:0] q_measured;
    logic                 ready;
    logic                 timeout;
    modport master (output enable, osc_in, env_hi, env_lo, input excite, q_measured, ready, timeout);
    modport slave  (input enable, osc_in, env_hi, env_lo, output excite, q_measured, ready, timeout);
endinterface

// File: rtl/q_ringdown_meter_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, async active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q_o, meta_q} <= 2'b00;
        else     {q_o, meta_q} <= {meta_q, d_i};
endmodule

// File: rtl/q_ringdown_meter.sv
// q_ringdown_meter: excites the resonator and counts ring-down cycles between thresholds.
// Define Q_AVG_EN to publish the mean of four back-to-back measurements.
module q_ringdown_meter
    import q_meter_pkg::*;
#(
    parameter int BUS_WIDTH      = 10,
    parameter int EXCITE_CYCLES  = 64,
    parameter int SETTLE_CYCLES  = 256,
    parameter int TIMER_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    q_ringdown_meter_if.slave bus_io
);
    localparam logic [TIMER_WIDTH-1:0] EXC_END = TIMER_WIDTH'(EXCITE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] SET_END = TIMER_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TO_END  = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    state_t               state_q, state_d;
    logic [TIMER_WIDTH-1:0] tmr_q, tmr_d;
    logic [BUS_WIDTH-1:0] cnt_q, cnt_d, q_q, q_d, res;
    logic                 hit_q, hit_d, tout_q, tout_d, pub_q, pub_d, osc_q;
    logic                 osc_s, hi_s, lo_s, rise, to_hit, normal, fin, last;
`ifdef Q_AVG_EN
    logic [BUS_WIDTH+1:0] acc_q, acc_d, sum;
    logic [$clog2(AVG_DEPTH)-1:0] idx_q, idx_d;
    logic                 tor_q, tor_d;
`endif
    sync_2ff u_sync_osc (.clk(clk), .rst(rst), .d_i(bus_io.osc_in), .q_o(osc_s));
    sync_2ff u_sync_hi  (.clk(clk), .rst(rst), .d_i(bus_io.env_hi), .q_o(hi_s));
    sync_2ff u_sync_lo  (.clk(clk), .rst(rst), .d_i(bus_io.env_lo), .q_o(lo_s));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            {hit_q, tout_q, pub_q, osc_q} <= 4'b0000;
`ifdef Q_AVG_EN
            acc_q   <= '0;
            idx_q   <= '0;
            tor_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            {hit_q, tout_q, pub_q, osc_q} <= {hit_d, tout_d, pub_d, osc_s};
`ifdef Q_AVG_EN
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            tor_q   <= tor_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        to_hit  = tmr_q == TO_END;
        case (state_q)
            IDLE:    state_d = EXCITE;
            EXCITE:  state_d = tmr_q == EXC_END ? WAIT_HI : EXCITE;
            WAIT_HI: state_d = (!hit_q || to_hit) ? DONE : !hi_s ? COUNT : WAIT_HI;
            COUNT:   state_d = (!lo_s || to_hit) ? DONE : COUNT;
            DONE:    state_d = pub_q ? SETTLE : EXCITE;
            SETTLE:  state_d = tmr_q == SET_END ? EXCITE : SETTLE;
            default: state_d = IDLE;
        endcase
        if (!bus_io.enable) state_d = IDLE;
    end
    // Timer is shared by all phases; WAIT_HI and COUNT form one timeout window.
    always_comb begin
        rise   = osc_s & ~osc_q;
        normal = (state_q == WAIT_HI && !hit_q) || (state_q == COUNT && !lo_s);
        cnt_d  = state_q == COUNT ? cnt_q + BUS_WIDTH'(rise && cnt_q != '1) : '0;
        res    = !normal ? '1 : state_q == COUNT ? cnt_d : '0;
        fin    = state_d == DONE;
        tmr_d  = (state_d != state_q && !(state_q == WAIT_HI && state_d == COUNT)) ? '0 : tmr_q + 1'b1;
        hit_d  = state_q == EXCITE ? hit_q | hi_s : state_q == WAIT_HI && hit_q;
`ifdef Q_AVG_EN
        sum    = acc_q + (BUS_WIDTH + 2)'(res);
        last   = idx_q == ($clog2(AVG_DEPTH))'(AVG_DEPTH - 1);
        acc_d  = !bus_io.enable ? '0 : fin ? (last ? '0 : sum) : acc_q;
        idx_d  = !bus_io.enable ? '0 : fin ? idx_q + 1'b1 : idx_q;
        tor_d  = !bus_io.enable ? 1'b0 : fin ? !last && (tor_q | !normal) : tor_q;
        q_d    = fin && last ? BUS_WIDTH'(sum >> AVG_SHIFT) : q_q;
        tout_d = fin && last ? tor_q | !normal : tout_q;
`else
        last   = 1'b1;
        q_d    = fin ? res : q_q;
        tout_d = fin ? !normal : tout_q;
`endif
        pub_d  = fin ? last : pub_q;
    end
    always_comb begin
        bus_io.excite     = state_q == EXCITE;
        bus_io.ready      = state_q == DONE && pub_q;
        bus_io.timeout    = state_q == DONE && pub_q && tout_q;
        bus_io.q_measured = q_q;
    end
endmodule
